// File: rtl/legv8_pkg.sv
// Shared LEGv8 core definitions: FSM states, opcode fields, decoded operations
// and the instruction classifier used by the DECODE state.
package legv8_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_LDUR = 4'd6,
    OP_STUR = 4'd7,
    OP_CBZ  = 4'd8,
    OP_B    = 4'd9,
    OP_HLT  = 4'd10,
    OP_ILL  = 4'd11
  } op_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [31:0] HLT_WORD = 32'hD440_0000;

  // Longest opcode field first so the shorter encodings cannot alias.
  function automatic op_e decode_op(input logic [31:0] ir);
    op_e op;
    op = OP_ILL;
    if (ir == HLT_WORD)              op = OP_HLT;
    else if (ir[31:21] == OPC_ADD)   op = OP_ADD;
    else if (ir[31:21] == OPC_SUB)   op = OP_SUB;
    else if (ir[31:21] == OPC_AND)   op = OP_AND;
    else if (ir[31:21] == OPC_ORR)   op = OP_ORR;
    else if (ir[31:21] == OPC_LDUR)  op = OP_LDUR;
    else if (ir[31:21] == OPC_STUR)  op = OP_STUR;
    else if (ir[31:22] == OPC_ADDI)  op = OP_ADDI;
    else if (ir[31:22] == OPC_SUBI)  op = OP_SUBI;
    else if (ir[31:24] == OPC_CBZ)   op = OP_CBZ;
    else if (ir[31:26] == OPC_B)     op = OP_B;
    else                             op = OP_ILL;
    return op;
  endfunction

endpackage

// File: rtl/legv8_regfile.sv
// 32-entry LEGv8 register bank: two combinational reads, one synchronous write,
// register 31 (XZR) reads as zero and ignores writes.
module legv8_regfile #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4:0]            ra_addr_i,
  input  logic [4:0]            rb_addr_i,
  output logic [DATA_WIDTH-1:0] ra_data_o,
  output logic [DATA_WIDTH-1:0] rb_data_o,
  input  logic                  we_i,
  input  logic [4:0]            wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i
);
  logic [DATA_WIDTH-1:0] regs_q [0:30];

  // Register storage; XZR has no backing entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 5'd31)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports with XZR forced to zero.
  always_comb begin
    ra_data_o = (ra_addr_i == 5'd31) ? '0 : regs_q[ra_addr_i];
    rb_data_o = (rb_addr_i == 5'd31) ? '0 : regs_q[rb_addr_i];
  end

endmodule

// File: rtl/legv8_multicycle_core.sv
// LEGv8 multi-cycle core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM driving
// req/ready instruction and data memory ports; all outputs are registered.
module legv8_multicycle_core
  import legv8_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  retire,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  halted,
  output logic                  error
);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4'd4);

  state_e                state_q, state_d;
  op_e                   op_q, op_d, op_dec;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic                  imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [DATA_WIDTH-1:0] imem_addr_q, imem_addr_d, dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic                  retire_q, retire_d, halted_q, halted_d, error_q, error_d;
  logic [4:0]            rn_addr, rm_addr;
  logic [DATA_WIDTH-1:0] rf_a, rf_b;
  logic                  rf_we;

  legv8_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk_i     (clock),
    .rst_ni    (reset),
    .ra_addr_i (rn_addr),
    .rb_addr_i (rm_addr),
    .ra_data_o (rf_a),
    .rb_data_o (rf_b),
    .we_i      (rf_we),
    .wa_i      (ir_q[4:0]),
    .wd_i      (res_q)
  );

  // Instruction classification and register-read addresses.
  always_comb begin
    op_dec  = decode_op(ir_q);
    rn_addr = ir_q[9:5];
    rm_addr = ((op_dec == OP_CBZ) || (op_dec == OP_STUR)) ? ir_q[4:0] : ir_q[20:16];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    a_d          = a_q;
    b_d          = b_q;
    imm_d        = imm_q;
    res_d        = res_q;
    imem_addr_d  = imem_addr_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_wdata_d = dmem_wdata_q;
    error_d      = error_q;
    retire_d     = 1'b0;
    rf_we        = 1'b0;
    case (state_q)
      S_FETCH: begin
        // imem_req_q is low for the first cycle after reset; wait for it.
        if (imem_req_q && imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        op_d = op_dec;
        a_d  = rf_a;
        b_d  = rf_b;
        case (op_dec)
          OP_ADDI, OP_SUBI: imm_d = {{(DATA_WIDTH-12){1'b0}}, ir_q[21:10]};
          OP_LDUR, OP_STUR: imm_d = DATA_WIDTH'($signed(ir_q[20:12]));
          OP_CBZ:           imm_d = DATA_WIDTH'($signed({ir_q[23:5], 2'b00}));
          OP_B:             imm_d = DATA_WIDTH'($signed({ir_q[25:0], 2'b00}));
          default:          imm_d = '0;
        endcase
        if (op_dec == OP_ILL) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else if (op_dec == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (op_q)
          OP_ADD:  res_d = a_q + b_q;
          OP_SUB:  res_d = a_q - b_q;
          OP_AND:  res_d = a_q & b_q;
          OP_ORR:  res_d = a_q | b_q;
          OP_ADDI: res_d = a_q + imm_q;
          OP_SUBI: res_d = a_q - imm_q;
          OP_LDUR, OP_STUR: begin
            dmem_addr_d  = a_q + imm_q;
            dmem_we_d    = (op_q == OP_STUR);
            dmem_wdata_d = b_q;
            state_d      = S_MEM;
          end
          OP_CBZ: begin
            pc_d     = (b_q == '0) ? (pc_q + imm_q) : (pc_q + PC_STEP);
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OP_B: begin
            pc_d     = pc_q + imm_q;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            state_d = S_HALT;
            error_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ready) begin
          if (dmem_we_q) begin
            pc_d     = pc_q + PC_STEP;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WRITEBACK;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WRITEBACK: begin
        rf_we    = 1'b1;
        pc_d     = pc_q + PC_STEP;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        error_d = 1'b1;
      end
    endcase
    // Request outputs are registered views of the state being entered.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    halted_d   = (state_d == S_HALT);
    if (state_d == S_FETCH) begin
      imem_addr_d = pc_d;
    end else begin
      imem_addr_d = imem_addr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      op_q         <= OP_ILL;
      ir_q         <= 32'd0;
      pc_q         <= PC_RESET;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      res_q        <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      res_q        <= res_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      retire_q     <= retire_d;
      halted_q     <= halted_d;
      error_q      <= error_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign retire     = retire_q;
  assign pc_out     = pc_q;
  assign halted     = halted_q;
  assign error      = error_q;

endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Directed bench for legv8_multicycle_core: a 64-bit core with stalling
// memory models and a 32-bit core with zero-wait memories on a shared reset.
module tb_legv8_multicycle_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        imem_req, dmem_req, dmem_we, retire, halted, error;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, pc_out;
  logic [31:0] imem_rdata = 32'd0;
  logic [63:0] dmem_rdata = 64'd0;

  logic        imem_req32, dmem_req32, dmem_we32, retire32, halted32, error32;
  logic        imem_ready32 = 1'b0, dmem_ready32 = 1'b0;
  logic [31:0] imem_addr32, dmem_addr32, dmem_wdata32, pc_out32;
  logic [31:0] imem_rdata32 = 32'd0;
  logic [31:0] dmem_rdata32 = 32'd0;

  legv8_multicycle_core #(.DATA_WIDTH(64), .PC_RESET(64'd0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .pc_out(pc_out), .halted(halted), .error(error)
  );

  legv8_multicycle_core #(.DATA_WIDTH(32), .PC_RESET(32'd0)) dut32 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(imem_ready32), .imem_rdata(imem_rdata32),
    .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32),
    .dmem_ready(dmem_ready32), .dmem_rdata(dmem_rdata32),
    .retire(retire32), .pc_out(pc_out32), .halted(halted32), .error(error32)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [0:63];
  logic [63:0] dmem [0:127];
  int          imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
  int          tick = 0, t0 = -1, addr_moves = 0;
  logic        d_busy = 1'b0;
  logic [63:0] held_addr = 64'd0;
  logic [63:0] fetch_q[$];
  logic [63:0] st_addr_q[$];
  logic [63:0] st_data_q[$];
  int          retire_t[$];
  logic [31:0] st32_addr = 32'd0, st32_data = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 64-bit memory models: ready after a programmable number of wait cycles.
  always @(negedge clock) begin
    tick = tick + 1;
    if (imem_req && (t0 < 0)) t0 = tick;
    if (retire) retire_t.push_back(tick - t0);
    if (imem_req) begin
      if (icnt >= imem_wait) begin
        imem_ready = 1'b1;
        imem_rdata = imem[imem_addr[7:2]];
        fetch_q.push_back(imem_addr);
        icnt = 0;
      end else begin
        imem_ready = 1'b0;
        icnt++;
      end
    end else begin
      imem_ready = 1'b0;
      icnt = 0;
    end
    if (dmem_req) begin
      if (!d_busy) begin
        held_addr = dmem_addr;
        d_busy = 1'b1;
      end else if (dmem_addr !== held_addr) begin
        addr_moves++;
      end
      if (dcnt >= dmem_wait) begin
        dmem_ready = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr[9:3]] = dmem_wdata;
          st_addr_q.push_back(dmem_addr);
          st_data_q.push_back(dmem_wdata);
        end else begin
          dmem_rdata = dmem[dmem_addr[9:3]];
        end
        dcnt = 0;
      end else begin
        dmem_ready = 1'b0;
        dcnt++;
      end
    end else begin
      dmem_ready = 1'b0;
      dcnt = 0;
      d_busy = 1'b0;
    end
  end

  // 32-bit core: ADDI X1,#5; ADDI X2,#7; SUB X3,X1,X2; STUR X3,[XZR,#4]; HLT.
  always @(negedge clock) begin
    imem_ready32 = imem_req32;
    case (imem_addr32[4:2])
      3'd0:    imem_rdata32 = 32'h910017E1;
      3'd1:    imem_rdata32 = 32'h91001FE2;
      3'd2:    imem_rdata32 = 32'hCB020023;
      3'd3:    imem_rdata32 = 32'hF80043E3;
      default: imem_rdata32 = 32'hD4400000;
    endcase
    dmem_ready32 = dmem_req32;
    if (dmem_req32 && dmem_we32) begin
      st32_addr = dmem_addr32;
      st32_data = dmem_wdata32;
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    fetch_q.delete();
    st_addr_q.delete();
    st_data_q.delete();
    retire_t.delete();
    t0 = -1;
    addr_moves = 0;
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && (n < 3000)) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
  endtask

  initial begin
    int busy;
    for (int i = 0; i < 64; i++) imem[i] = 32'hD4400000;
    for (int i = 0; i < 128; i++) dmem[i] = 64'd0;
    imem[0]  = 32'h910017E1; // ADDI X1,XZR,#5
    imem[1]  = 32'h91001FE2; // ADDI X2,XZR,#7
    imem[2]  = 32'h8B020023; // ADD  X3,X1,X2
    imem[3]  = 32'h910403E0; // ADDI X0,XZR,#0x100
    imem[4]  = 32'hF8008003; // STUR X3,[X0,#8]
    imem[5]  = 32'hF8408004; // LDUR X4,[X0,#8]
    imem[6]  = 32'hF8010004; // STUR X4,[X0,#16]
    imem[7]  = 32'h910003E5; // ADDI X5,XZR,#0
    imem[8]  = 32'hB4000065; // 0x20 CBZ X5,+3 -> 0x2C
    imem[11] = 32'h14000005; // 0x2C B +5 -> 0x40
    imem[15] = 32'h14000009; // 0x3C B +9 -> 0x60
    imem[16] = 32'h17FFFFFF; // 0x40 B -1 -> 0x3C
    imem[24] = 32'h910007E2; // ADDI X2,XZR,#1
    imem[25] = 32'hCB0203E1; // SUB  X1,XZR,X2
    imem[26] = 32'hF8018001; // STUR X1,[X0,#24]
    imem[27] = 32'h910027FF; // ADDI X31,XZR,#9
    imem[28] = 32'hF802001F; // STUR X31,[X0,#32]
    imem[29] = 32'h910007E5; // ADDI X5,XZR,#1
    imem[30] = 32'hB4000065; // 0x78 CBZ X5,+3 not taken -> 0x7C HLT

    // Reset values
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ctrl", 64'({imem_req, dmem_req, dmem_we, retire, halted, error}), 64'd0);
    check("rst_imem_addr", imem_addr, 64'd0);
    check("rst_dmem_addr_wdata", dmem_addr | dmem_wdata, 64'd0);
    check("rst_pc", pc_out, 64'd0);

    // Main program with three-wait-state data memory
    dmem_wait = 3;
    apply_reset();
    wait_halt("prog");
    check("prog_error", 64'(error), 64'd0);
    check("prog_pc", pc_out, 64'h7C);
    check("retire_count", 64'(retire_t.size()), 64'd19);
    check("retire_0", 64'(retire_t[0]), 64'd4);
    check("retire_1", 64'(retire_t[1]), 64'd8);
    check("retire_2", 64'(retire_t[2]), 64'd12);
    check("stur_cycles", 64'(retire_t[4] - retire_t[3]), 64'd7);
    check("ldur_cycles", 64'(retire_t[5] - retire_t[4]), 64'd8);
    check("fetch_count", 64'(fetch_q.size()), 64'd20);
    check("cbz_taken", fetch_q[9], 64'h2C);
    check("b_back", fetch_q[11], 64'h3C);
    check("b_fwd", fetch_q[12], 64'h60);
    check("cbz_not_taken", fetch_q[19], 64'h7C);
    check("store_count", 64'(st_addr_q.size()), 64'd4);
    check("stur_addr", st_addr_q[0], 64'h108);
    check("stur_x3", st_data_q[0], 64'd12);
    check("ldur_x4", st_data_q[1], 64'd12);
    check("sub_allones", st_data_q[2], 64'hFFFF_FFFF_FFFF_FFFF);
    check("xzr_zero", st_data_q[3], 64'd0);
    check("dmem_addr_stable", 64'(addr_moves), 64'd0);
    check("w32_halted", 64'({halted32, error32}), 64'b10);
    check("w32_pc", 64'(pc_out32), 64'h10);
    check("w32_st_addr", 64'(st32_addr), 64'h4);
    check("w32_sub", 64'(st32_data), 64'hFFFF_FFFE);

    // Illegal opcode halts with error and issues no further fetches
    imem[0] = 32'hFFFF_FFFF;
    apply_reset();
    wait_halt("ill");
    check("ill_error", 64'(error), 64'd1);
    check("ill_pc", pc_out, 64'd0);
    busy = 0;
    repeat (10) begin
      @(negedge clock);
      if (imem_req) busy++;
    end
    check("ill_no_req", 64'(busy), 64'd0);

    // Reset in the middle of a stalled fetch
    imem[0] = 32'h910017E1;
    imem_wait = 20;
    apply_reset();
    repeat (4) @(negedge clock);
    check("stall_req", 64'({imem_req, imem_ready}), 64'b10);
    #2 reset = 1'b0;
    #1;
    check("midrst_ctrl", 64'({imem_req, dmem_req, retire, halted, error}), 64'd0);
    check("midrst_addr", imem_addr, 64'd0);
    check("midrst_w32", 64'({imem_req32, dmem_req32, retire32, halted32, error32}), 64'd0);
    imem_wait = 0;
    apply_reset();
    wait_halt("restart");
    check("restart_fetch0", fetch_q[0], 64'd0);
    check("restart_pc", pc_out, 64'h7C);
    check("restart_error", 64'(error), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_core.md
Name: legv8_multicycle_core

Overview:
- Next-generation LEGv8 processor core that replaces the single-cycle datapath with a multi-cycle FSM.
- Data width is parametrised; instruction and data memory are external, reached through req/ready handshake ports so memories may stall.
- Executes ADD/SUB/AND/ORR, ADDI/SUBI, LDUR/STUR, CBZ, B and HLT. Any other encoding halts the core with an error flag.
- Sits between the testbench/SoC memories and the existing register-bank and ALU conventions.

Parameters:
- DATA_WIDTH, 64, register/ALU/address width; legal values 32 or 64.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  instruction fetch request.
- imem_addr  out  DATA_WIDTH  fetch byte address (= PC).
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  DATA_WIDTH  data byte address.
- dmem_wdata  out  DATA_WIDTH  store data.
- dmem_ready  in  1  access complete; dmem_rdata valid for loads.
- dmem_rdata  in  DATA_WIDTH  load data.
- retire  out  1  one-cycle pulse when an instruction completes.
- pc_out  out  DATA_WIDTH  architectural PC.
- halted  out  1  core stopped (HLT or illegal opcode).
- error  out  1  halt was caused by an illegal opcode.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=FETCH, PC=PC_RESET, all 31 registers=0.
  - All *_req, retire, halted and error low; addresses/wdata 0.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_ready.
  - On imem_ready: latch IR -> DECODE.
- DECODE:
  - Read Rn=IR[9:5].
  - Second operand: IR[4:0] for CBZ/STUR, IR[20:16] otherwise.
  - Latch operands and the sign/zero-extended immediate.
  - Illegal opcode -> HALT with error=1.
  - HLT (IR=0xD4400000) -> HALT with error=0.
- EXECUTE, by opcode:
  - ADD 10001011000: Rn+Rm.
  - SUB 11001011000: Rn-Rm.
  - AND 10001010000: Rn&Rm.
  - ORR 10101010000: Rn|Rm.
  - ADDI 1001000100, SUBI 1101000100: Rn ± zero-extended IR[21:10]. Result -> WRITEBACK.
  - LDUR 11111000010, STUR 11111000000: addr = Rn + sign-extended IR[20:12] -> MEM.
  - CBZ 10110100: if Rt==0, PC += sext(IR[23:5])<<2, else PC += 4. Retire -> FETCH.
  - B 000101: PC += sext(IR[25:0])<<2. Retire -> FETCH.
- MEM:
  - dmem_req=1; addr, we and wdata held stable until dmem_ready.
  - STUR completes -> PC += 4, retire -> FETCH.
  - LDUR latches dmem_rdata -> WRITEBACK.
- WRITEBACK: write Rd=IR[4:0]; PC += 4; retire=1 -> FETCH.
- HALT: absorbing. halted=1; no requests issued; only reset exits.
- Register 31 (XZR): reads as 0; writes discarded.
- Arithmetic: modulo 2^DATA_WIDTH; branch targets wrap the same way. No flags.
- Latency, zero wait states:
  - ALU ops: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/B: 3 cycles.
  - Each *_ready cycle waited adds one cycle.
- Ready signals are ignored when the matching req is low.
- Reset asserted mid-handshake drops req immediately; no transaction is retried.
- pc_out updates in the same edge as retire.

Decomposition:
- legv8_pkg:
  - state enum.
  - Opcode constants (11/10/8/6-bit forms) and the HLT word.
  - ALU operation enum.
- Sub-module legv8_regfile:
  - 32 x DATA_WIDTH, XZR hard-wired.
  - Two combinational read ports, one synchronous write port, async active-low reset.
- ALU and immediate extension stay inline in the core.

Test Plan:
- ADDI X1,XZR,#5; ADDI X2,XZR,#7; ADD X3,X1,X2; HLT, zero-wait memories -> X3=12, retire pulses at cycles 4/8/12, halted=1, error=0.
- STUR X3,[X0,#8] then LDUR X4,[X0,#8] with X0=0x100, dmem_ready delayed 3 cycles -> dmem_addr=0x108 held stable while waiting, wdata=12, X4=12, load takes 8 cycles.
- CBZ X5,+3 with X5=0 at PC=0x20 -> next fetch 0x2C. With X5=1 -> next fetch 0x24.
- B -1 at PC=0x40 -> fetch 0x3C. SUB X1,XZR,X2 with X2=1 -> X1=all-ones. ADDI X31 -> X31 still reads 0.
- Fetch returns 0xFFFFFFFF -> halted=1, error=1, no further imem_req.
- Reset pulled low while imem_req high awaiting ready -> all outputs at reset values in the same cycle; after release, fetch restarts at PC_RESET. Repeat with DATA_WIDTH=32.
